// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: entry layout, default depth, ZERO_REG.
// The optional flush port is enabled by defining ROB_FLUSH_EN.
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package reorder_buffer_pkg;
    localparam int ROB_SIZE_DEFAULT = 16;

    typedef struct packed {
        logic        valid;
        logic        complete;
        logic        is_store;
        logic [4:0]  dest_reg;
        logic [31:0] value;
        logic [31:0] dest_addr;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrap-around pointer register used for the reorder buffer head and tail.
// Depth is a power of two, so natural overflow of the W-bit register gives the wrap.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] value
);
    logic [W-1:0] value_reg;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            value_reg <= '0;
        end else if (enable) begin
            value_reg <= value_reg + W'(1);
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate from dispatch, complete from CDB, retire at head.
// Define ROB_FLUSH_EN to add a flush input that empties the buffer.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
    parameter int TAG_W    = $clog2(ROB_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
`ifdef ROB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             dispatch_valid,
    input  logic [4:0]       dispatch_dest_reg,
    input  logic             dispatch_is_store,
    output logic [TAG_W-1:0] dispatch_tag,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic [31:0]      cdb_addr,
    output rob_entry_t       head_entry,
    output logic             head_ready
);
    rob_entry_t       entry_reg [ROB_SIZE];
    rob_entry_t       head_raw;
    logic [TAG_W-1:0] head_ptr;
    logic [TAG_W-1:0] tail_ptr;
    logic [TAG_W:0]   count_reg;
    logic [TAG_W:0]   count_next;
    logic             flush_active;
    logic             allocate;
    logic             retire;

`ifdef ROB_FLUSH_EN
    assign flush_active = flush;
`else
    assign flush_active = 1'b0;
`endif

    assign head_raw     = entry_reg[head_ptr];
    assign rob_full     = (count_reg == (TAG_W+1)'(ROB_SIZE));
    assign allocate     = dispatch_valid && !rob_full && !flush_active;
    assign head_ready   = head_raw.valid && head_raw.complete && !flush_active;
    assign retire       = head_ready;
    assign head_entry   = (count_reg == '0) ? '0 : head_raw;
    assign dispatch_tag = tail_ptr;

    rob_ptr #(.W(TAG_W)) u_head_ptr (
        .clock  (clock),
        .reset  (reset),
        .clear  (flush_active),
        .enable (retire),
        .value  (head_ptr)
    );

    rob_ptr #(.W(TAG_W)) u_tail_ptr (
        .clock  (clock),
        .reset  (reset),
        .clear  (flush_active),
        .enable (allocate),
        .value  (tail_ptr)
    );

    // Same-slot priority: allocate, then retire, then completion. Completion only
    // lands on an entry that was already valid before this edge.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (!reset || flush_active) begin
                entry_reg[i] <= '0;
            end else if (allocate && tail_ptr == TAG_W'(i)) begin
                entry_reg[i].valid     <= 1'b1;
                entry_reg[i].complete  <= 1'b0;
                entry_reg[i].is_store  <= dispatch_is_store;
                entry_reg[i].dest_reg  <= dispatch_dest_reg;
                entry_reg[i].value     <= '0;
                entry_reg[i].dest_addr <= '0;
            end else if (retire && head_ptr == TAG_W'(i)) begin
                entry_reg[i].valid    <= 1'b0;
                entry_reg[i].complete <= 1'b0;
            end else if (cdb_valid && cdb_tag == TAG_W'(i) && entry_reg[i].valid) begin
                entry_reg[i].value    <= cdb_value;
                entry_reg[i].complete <= 1'b1;
                if (entry_reg[i].is_store) begin
                    entry_reg[i].dest_addr <= cdb_addr;
                end
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (allocate && !retire) begin
            count_next = count_reg + (TAG_W+1)'(1);
        end else if (retire && !allocate) begin
            count_next = count_reg - (TAG_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush_active) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: the driver queues expected per-cycle status and
// expected retirements; a negedge monitor pops and compares them against the DUT.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int TAG_W = 4;

    typedef struct {
        int tag;
        bit full;
        bit ready;
        bit hvalid;
        int dest;
    } status_t;

    typedef struct {
        int          dest;
        logic [31:0] value;
        logic [31:0] addr;
        bit          store;
    } retire_t;

    logic             clock;
    logic             reset;
    logic             flush;
    logic             dispatch_valid;
    logic [4:0]       dispatch_dest_reg;
    logic             dispatch_is_store;
    logic [TAG_W-1:0] dispatch_tag;
    logic             rob_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic [31:0]      cdb_addr;
    rob_entry_t       head_entry;
    logic             head_ready;

    status_t status_q[$];
    retire_t retire_q[$];
    status_t s_cur;
    retire_t r_cur;
    int      checks = 0;
    int      errors = 0;

    reorder_buffer #(.ROB_SIZE(16)) dut (
        .clock             (clock),
        .reset             (reset),
`ifdef ROB_FLUSH_EN
        .flush             (flush),
`endif
        .dispatch_valid    (dispatch_valid),
        .dispatch_dest_reg (dispatch_dest_reg),
        .dispatch_is_store (dispatch_is_store),
        .dispatch_tag      (dispatch_tag),
        .rob_full          (rob_full),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_value         (cdb_value),
        .cdb_addr          (cdb_addr),
        .head_entry        (head_entry),
        .head_ready        (head_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares one queued status per cycle and pops a retirement whenever one is due.
    always @(negedge clock) begin
        if (status_q.size() > 0) begin
            s_cur = status_q.pop_front();
            check("dispatch_tag", 64'(dispatch_tag), 64'(s_cur.tag));
            check("rob_full", 64'(rob_full), 64'(s_cur.full));
            check("head_ready", 64'(head_ready), 64'(s_cur.ready));
            check("head_valid", 64'(head_entry.valid), 64'(s_cur.hvalid));
            if (s_cur.dest >= 0) check("head_dest", 64'(head_entry.dest_reg), 64'(s_cur.dest));
            if (!s_cur.hvalid) check("head_zero", 64'(head_entry == '0), 64'd1);
            if (s_cur.ready && head_ready) begin
                if (retire_q.size() == 0) begin
                    check("retire_expected", 64'd1, 64'd0);
                end else begin
                    r_cur = retire_q.pop_front();
                    check("retire_dest", 64'(head_entry.dest_reg), 64'(r_cur.dest));
                    check("retire_value", 64'(head_entry.value), 64'(r_cur.value));
                    check("retire_addr", 64'(head_entry.dest_addr), 64'(r_cur.addr));
                    check("retire_store", 64'(head_entry.is_store), 64'(r_cur.store));
                    $display("retire dest=%0d value=%08h addr=%08h store=%0d",
                             head_entry.dest_reg, head_entry.value, head_entry.dest_addr,
                             head_entry.is_store);
                end
            end
        end
    end

    task automatic step(input bit dv, input int dreg, input bit dst,
                        input bit cv, input int ctag, input logic [31:0] cval,
                        input logic [31:0] caddr,
                        input int etag, input bit efull, input bit eready,
                        input bit ehv, input int edest);
        status_t s;
        dispatch_valid    = dv;
        dispatch_dest_reg = 5'(dreg);
        dispatch_is_store = dst;
        cdb_valid         = cv;
        cdb_tag           = TAG_W'(ctag);
        cdb_value         = cval;
        cdb_addr          = caddr;
        s = '{etag, efull, eready, ehv, edest};
        status_q.push_back(s);
        @(posedge clock);
        #1;
    endtask

    task automatic exp_retire(input int dest, input logic [31:0] value,
                              input logic [31:0] addr, input bit store);
        retire_t r;
        r = '{dest, value, addr, store};
        retire_q.push_back(r);
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        flush             = 1'b0;
        dispatch_valid    = 1'b0;
        dispatch_dest_reg = '0;
        dispatch_is_store = 1'b0;
        cdb_valid         = 1'b0;
        cdb_tag           = '0;
        cdb_value         = '0;
        cdb_addr          = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        // Single entry: allocate, complete, retire.
        step(1, 3, 0, 0, 0, 0, 0,                   0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 3);
        exp_retire(3, 32'hDEADBEEF, 0, 0);
        step(0, 0, 0, 1, 0, 32'hDEADBEEF, 0,        1, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0,                   1, 0, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, -1);

        // Fill to full, refused dispatch, retire one, wrap to tag 0.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, -1);
        for (int i = 0; i < 16; i++) begin
            step(1, i + 1, 0, 0, 0, 0, 0,           i, 0, 0, (i > 0), (i > 0) ? 1 : -1);
        end
        step(1, 20, 0, 0, 0, 0, 0,                  0, 1, 0, 1, 1);
        exp_retire(1, 32'h55, 0, 0);
        step(0, 0, 0, 1, 0, 32'h55, 0,              0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0,                   0, 1, 1, 1, 1);
        step(1, 9, 0, 0, 0, 0, 0,                   0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0,                   1, 1, 0, 1, 2);

        // Out-of-order completion with a duplicate; non-store ignores cdb_addr.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, -1);
        step(1, 4, 0, 0, 0, 0, 0,                   0, 0, 0, 0, -1);
        step(1, 5, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 4);
        step(1, 6, 0, 0, 0, 0, 0,                   2, 0, 0, 1, 4);
        step(0, 0, 0, 1, 2, 32'h22, 32'hABC,        3, 0, 0, 1, 4);
        step(0, 0, 0, 1, 1, 32'h11, 32'hABC,        3, 0, 0, 1, 4);
        step(0, 0, 0, 1, 1, 32'h12, 32'hABC,        3, 0, 0, 1, 4);
        exp_retire(4, 32'h10, 0, 0);
        exp_retire(5, 32'h12, 0, 0);
        exp_retire(6, 32'h22, 0, 0);
        step(0, 0, 0, 1, 0, 32'h10, 32'hABC,        3, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 0, 0,                   3, 0, 1, 1, 4);
        step(0, 0, 0, 0, 0, 0, 0,                   3, 0, 1, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0,                   3, 0, 1, 1, 6);
        step(0, 0, 0, 0, 0, 0, 0,                   3, 0, 0, 0, -1);

        // Store entry, CDB to an invalid tag, allocate and retire in one cycle.
        step(1, 0, 1, 0, 0, 0, 0,                   3, 0, 0, 0, -1);
        step(0, 0, 0, 1, 5, 32'h99, 32'h2000,       4, 0, 0, 1, 0);
        exp_retire(0, 32'h7, 32'h1000, 1);
        step(0, 0, 0, 1, 3, 32'h7, 32'h1000,        4, 0, 0, 1, 0);
        step(1, 7, 0, 0, 0, 0, 0,                   4, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0,                   5, 0, 0, 1, 7);
        exp_retire(7, 32'h1, 0, 0);
        step(0, 0, 0, 1, 4, 32'h1, 0,               5, 0, 0, 1, 7);
        step(0, 0, 0, 0, 0, 0, 0,                   5, 0, 1, 1, 7);
        step(0, 0, 0, 0, 0, 0, 0,                   5, 0, 0, 0, -1);

`ifdef ROB_FLUSH_EN
        // Flush with a ready head and a concurrent dispatch.
        step(1, 1, 0, 0, 0, 0, 0,                   5, 0, 0, 0, -1);
        step(1, 2, 0, 0, 0, 0, 0,                   6, 0, 0, 1, 1);
        step(1, 3, 0, 0, 0, 0, 0,                   7, 0, 0, 1, 1);
        step(1, 4, 0, 0, 0, 0, 0,                   8, 0, 0, 1, 1);
        step(0, 0, 0, 1, 5, 32'h3, 0,               9, 0, 0, 1, 1);
        flush = 1'b1;
        step(1, 9, 0, 0, 0, 0, 0,                   9, 0, 0, 1, 1);
        flush = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, -1);
        step(1, 5, 0, 0, 0, 0, 0,                   0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 5);
`endif

        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        repeat (2) @(posedge clock);
        check("retire_queue_drained", 64'(retire_q.size()), 64'd0);
        check("status_queue_drained", 64'(status_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
